sdm_sample_scheduler: RTL and testbench
=======================================

// Module: sdm_sample_scheduler
// PURPOSE
//  Sample-rate scheduler ahead of sdm_modulator. Accepts PCM samples at Fs over a
//  valid/ready stream and holds each one on the modulator input for OSR clocks of
//  the 2.8224 MHz modulator clock (OSR=64 -> Fs=44.1 kHz).
//  - One-entry look-ahead buffer absorbs upstream jitter.
//  - Inserts mute (zero) samples on underrun and counts them.
//  - Sequences start/stop of the modulator stream via enable.
// PARAMETERS
//  DW      16               PCM sample width (two's complement), equals modulator din width
//  OSR     64               modulator clocks per PCM sample, >=2
//  CNT_W   $clog2(OSR)      phase counter width (derived)
//  UCNT_W  16               underrun counter width
// PORTS
//  clk            in   1       modulator clock, all logic on rising edge
//  rst_n          in   1       synchronous reset, active low
//  enable         in   1       run request from control
//  mute           in   1       force zero samples while still consuming input
//  s_valid        in   1       upstream sample valid
//  s_ready        out  1       upstream sample ready
//  s_data         in   DW      upstream PCM sample
//  mod_valid_in   out  1       to sdm_modulator valid_in
//  mod_din        out  DW      to sdm_modulator din
//  sample_tick    out  1       one-cycle pulse when a new sample is loaded into mod_din
//  underrun       out  1       one-cycle pulse on each inserted underrun zero
//  underrun_cnt   out  UCNT_W  saturating underrun count, cleared in IDLE->PRIME
//  state          out  2       00 IDLE, 01 PRIME, 10 RUN
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge)
//   - state=IDLE, phase=0, buf_vld=0.
//   - Outputs: mod_valid_in=0, mod_din=0, s_ready=0, sample_tick=0, underrun=0,
//     underrun_cnt=0.
//   - Reset mid-RUN drops mod_din and the buffer on the same edge.
//  Handshake
//   - Transfer when s_valid && s_ready.
//   - s_data must stay stable while s_valid=1 and s_ready=0.
//  IDLE
//   - s_ready=0, mod_valid_in=0, mod_din=0.
//   - enable=1 -> PRIME, and underrun_cnt<=0.
//  PRIME
//   - s_ready=1.
//   - enable=0 -> IDLE.
//   - On transfer: mod_din<=s_data, mod_valid_in<=1, phase<=0, sample_tick=1 next cycle,
//     -> RUN. Latency from transfer to mod_din is 1 clk.
//  RUN
//   - mod_valid_in=1.
//   - phase increments every clk, wraps OSR-1 -> 0. Each sample is held exactly OSR clks.
//   - s_ready = !buf_vld || (phase==OSR-1).
//   - A transfer while phase!=OSR-1 writes buf (buf_vld<=1).
//  Boundary (phase==OSR-1), evaluated in priority order:
//   1. enable=0: next state IDLE.
//      - mod_valid_in<=0, mod_din<=0, buf_vld<=0 (buffered sample discarded).
//      - s_ready=0 this cycle.
//   2. buf_vld=1: mod_din<=buf (or 0 if mute).
//      - A simultaneous transfer refills buf, so buf_vld stays 1.
//   3. buf_vld=0 and transfer this cycle: mod_din<=s_data (or 0 if mute). This is not
//      an underrun.
//   4. Otherwise (underrun):
//      - mod_din<=0, underrun=1.
//      - underrun_cnt++ saturating at 2^UCNT_W-1.
//   - sample_tick=1 on the cycle after cases 2-4.
//  Other rules
//   - mute only substitutes zero. Input is still consumed, and muted samples are not
//     counted as underruns.
//   - enable deasserted mid-period: the current sample finishes its full OSR clks.
//   - No arithmetic on samples: data passes bit-exact.
// TESTING
//  T1: reset, enable=1, one sample 16'h4000 -> 1 clk later mod_din=16'h4000,
//      mod_valid_in=1, state=RUN, sample_tick pulses once.
//  T2: continuous stream 1,2,3 with s_valid always 1 -> each value held exactly 64 clks,
//      sample_tick every 64 clks, underrun_cnt=0.
//  T3: after sample 16'h1234 stop s_valid -> at next boundary mod_din=0, underrun pulse,
//      underrun_cnt=1. Resume: next value loads at the following boundary.
//  T4: buffer full, hold s_valid with -16384 -> s_ready=1 only at phase 63. Data accepted
//      exactly once per period, with no duplication or loss.
//  T5: enable=0 at phase 10 -> mod_valid_in stays 1 until phase 63, then 0;
//      IDLE after 54 clks; buffered sample dropped.
//  T6: mute=1 with stream 16'h7FFF -> mod_din=0, input still consumed at 1 per 64 clks,
//      underrun_cnt unchanged. rst_n=0 mid-RUN -> all outputs 0 on next edge.

Source files
------------

// File: rtl/sdm_sample_scheduler.sv
// Sample-rate scheduler feeding sdm_modulator: holds each PCM sample for OSR
// modulator clocks, with a one-entry look-ahead buffer and underrun muting.
module sdm_sample_scheduler #(
    parameter int DW     = 16,
    parameter int OSR    = 64,
    parameter int CNT_W  = $clog2(OSR),
    parameter int UCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mute,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    output logic              mod_valid_in,
    output logic [DW-1:0]     mod_din,
    output logic              sample_tick,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRIME = 2'b01,
        ST_RUN   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0]  PHASE_LAST = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0]  PHASE_ZERO = {CNT_W{1'b0}};
    localparam logic [UCNT_W-1:0] UCNT_MAX   = {UCNT_W{1'b1}};
    localparam logic [DW-1:0]     DATA_ZERO  = {DW{1'b0}};

    state_t              state_r, state_n;
    logic [CNT_W-1:0]    phase_r, phase_n;
    logic [DW-1:0]       buf_r, buf_n;
    logic                buf_vld_r, buf_vld_n;
    logic                mod_valid_r, mod_valid_n;
    logic [DW-1:0]       mod_din_r, mod_din_n;
    logic                tick_r, tick_n;
    logic                underrun_r, underrun_n;
    logic [UCNT_W-1:0]   ucnt_r, ucnt_n;
    logic                ready_s;
    logic                boundary_s;

    // Mute replaces the sample with zero but never alters pass-through data.
    function automatic logic [DW-1:0] gate_sample(input logic m, input logic [DW-1:0] d);
        return m ? DATA_ZERO : d;
    endfunction

    assign boundary_s = (phase_r == PHASE_LAST);

    // Next-state, handshake and datapath selection.
    always_comb begin
        state_n     = state_r;
        phase_n     = phase_r;
        buf_n       = buf_r;
        buf_vld_n   = buf_vld_r;
        mod_valid_n = mod_valid_r;
        mod_din_n   = mod_din_r;
        tick_n      = 1'b0;
        underrun_n  = 1'b0;
        ucnt_n      = ucnt_r;
        ready_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                phase_n     = PHASE_ZERO;
                buf_vld_n   = 1'b0;
                mod_valid_n = 1'b0;
                mod_din_n   = DATA_ZERO;
                if (enable) begin
                    state_n = ST_PRIME;
                    ucnt_n  = {UCNT_W{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PRIME: begin
                ready_s = 1'b1;
                if (!enable) begin
                    state_n = ST_IDLE;
                end else if (s_valid) begin
                    mod_din_n   = gate_sample(mute, s_data);
                    mod_valid_n = 1'b1;
                    phase_n     = PHASE_ZERO;
                    tick_n      = 1'b1;
                    state_n     = ST_RUN;
                end else begin
                    state_n = ST_PRIME;
                end
            end
            ST_RUN: begin
                if (!boundary_s) begin
                    phase_n = phase_r + CNT_W'(1);
                    ready_s = !buf_vld_r;
                    if (ready_s && s_valid) begin
                        buf_n     = s_data;
                        buf_vld_n = 1'b1;
                    end else begin
                        buf_vld_n = buf_vld_r;
                    end
                end else if (!enable) begin
                    // The buffered sample is discarded on stop.
                    state_n     = ST_IDLE;
                    phase_n     = PHASE_ZERO;
                    mod_valid_n = 1'b0;
                    mod_din_n   = DATA_ZERO;
                    buf_vld_n   = 1'b0;
                end else begin
                    ready_s = 1'b1;
                    phase_n = PHASE_ZERO;
                    tick_n  = 1'b1;
                    if (buf_vld_r) begin
                        mod_din_n = gate_sample(mute, buf_r);
                        buf_n     = s_data;
                        buf_vld_n = s_valid;
                    end else if (s_valid) begin
                        mod_din_n = gate_sample(mute, s_data);
                    end else begin
                        mod_din_n  = DATA_ZERO;
                        underrun_n = 1'b1;
                        ucnt_n     = (ucnt_r == UCNT_MAX) ? UCNT_MAX : ucnt_r + UCNT_W'(1);
                    end
                end
            end
            default: begin
                state_n     = ST_IDLE;
                phase_n     = PHASE_ZERO;
                buf_vld_n   = 1'b0;
                mod_valid_n = 1'b0;
                mod_din_n   = DATA_ZERO;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            phase_r     <= PHASE_ZERO;
            buf_r       <= DATA_ZERO;
            buf_vld_r   <= 1'b0;
            mod_valid_r <= 1'b0;
            mod_din_r   <= DATA_ZERO;
            tick_r      <= 1'b0;
            underrun_r  <= 1'b0;
            ucnt_r      <= {UCNT_W{1'b0}};
        end else begin
            state_r     <= state_n;
            phase_r     <= phase_n;
            buf_r       <= buf_n;
            buf_vld_r   <= buf_vld_n;
            mod_valid_r <= mod_valid_n;
            mod_din_r   <= mod_din_n;
            tick_r      <= tick_n;
            underrun_r  <= underrun_n;
            ucnt_r      <= ucnt_n;
        end
    end

    assign s_ready      = ready_s;
    assign mod_valid_in = mod_valid_r;
    assign mod_din      = mod_din_r;
    assign sample_tick  = tick_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = ucnt_r;
    assign state        = state_r;

endmodule

// File: tb/tb_sdm_sample_scheduler.sv
// Self-checking bench for sdm_sample_scheduler: directed scenarios plus random
// traffic against a queue-based transaction model of the scheduler.
module tb_sdm_sample_scheduler;

    localparam int DW  = 16;
    localparam int OSR = 64;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          mute;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          mod_valid_in;
    logic [DW-1:0] mod_din;
    logic          sample_tick;
    logic          underrun;
    logic [15:0]   underrun_cnt;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    sdm_sample_scheduler #(.DW(DW), .OSR(OSR), .UCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mute(mute),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .mod_valid_in(mod_valid_in), .mod_din(mod_din),
        .sample_tick(sample_tick), .underrun(underrun),
        .underrun_cnt(underrun_cnt), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: state 0 idle, 1 waiting for first sample, 2 running.
    // m_pos counts clocks into the current hold period, m_q holds accepted
    // samples not yet presented.
    int            m_state = 0;
    int            m_pos   = 0;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_out   = '0;
    logic          m_valid = 1'b0;
    logic          m_tick  = 1'b0;
    logic          m_und   = 1'b0;
    logic [15:0]   m_ucnt  = '0;
    logic          exp_ready, obs_ready, last_acc;

    function automatic logic [36:0] exp_vec();
        logic [1:0] st;
        st = m_state[1:0];
        return {st, m_valid, m_tick, m_und, m_out, m_ucnt};
    endfunction

    function automatic logic [36:0] obs_vec();
        return {state, mod_valid_in, sample_tick, underrun, mod_din, underrun_cnt};
    endfunction

    // One clock: drive inputs after a falling edge, advance model, return at next falling edge.
    task automatic step(input logic en, input logic mu, input logic sv, input logic [DW-1:0] sd);
        logic          acc;
        logic [DW-1:0] v;
        enable = en; mute = mu; s_valid = sv; s_data = sd;
        #1;
        if (m_state == 1)      exp_ready = 1'b1;
        else if (m_state == 2) exp_ready = (m_pos == OSR-1) ? en : (m_q.size() == 0);
        else                   exp_ready = 1'b0;
        obs_ready = s_ready;
        acc = sv && exp_ready;
        last_acc = acc && rst_n;
        m_tick = 1'b0;
        m_und  = 1'b0;
        if (!rst_n) begin
            m_state = 0; m_pos = 0; m_q.delete();
            m_out = '0; m_valid = 1'b0; m_ucnt = '0;
        end else if (m_state == 0) begin
            m_out = '0; m_valid = 1'b0; m_pos = 0; m_q.delete();
            if (en) begin m_state = 1; m_ucnt = '0; end
        end else if (m_state == 1) begin
            if (!en) m_state = 0;
            else if (acc) begin
                m_out = mu ? '0 : sd; m_valid = 1'b1; m_pos = 0; m_tick = 1'b1; m_state = 2;
            end
        end else if (m_pos == OSR-1) begin
            m_pos = 0;
            if (!en) begin
                m_state = 0; m_valid = 1'b0; m_out = '0; m_q.delete();
            end else begin
                m_tick = 1'b1;
                if (acc) m_q.push_back(sd);
                if (m_q.size() > 0) begin
                    v = m_q.pop_front();
                    m_out = mu ? '0 : v;
                end else begin
                    m_out = '0; m_und = 1'b1;
                    if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
                end
            end
        end else begin
            m_pos = m_pos + 1;
            if (acc) m_q.push_back(sd);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1, 16'hFFFF);
        step(1'b1, 1'b0, 1'b1, 16'hFFFF);
        n_checks++;
        if (obs_vec() !== 37'd0 || s_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got %h ready=%b, want 0 ready=0", obs_vec(), s_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_sample();
        int ticks = 0;
        restart();
        step(1'b1, 1'b0, 1'b1, 16'h4000);
        n_checks++;
        if ({mod_din, mod_valid_in, state, sample_tick} !== {16'h4000, 1'b1, 2'b10, 1'b1}) begin
            n_errors++;
            $display("FAIL first_sample: got din=%h v=%b st=%b tick=%b want 4000 1 10 1",
                     mod_din, mod_valid_in, state, sample_tick);
        end
        for (int i = 0; i < 62; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0000);
            if (sample_tick) ticks++;
        end
        n_checks++;
        if (ticks !== 0 || mod_din !== 16'h4000) begin
            n_errors++;
            $display("FAIL first_hold: got ticks=%0d din=%h want 0 4000", ticks, mod_din);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] nv = 16'd1;
        logic [DW-1:0] vals[$];
        int            cyc[$];
        restart();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 1'b1, nv);
            if (last_acc) nv = nv + 16'd1;
            if (sample_tick) begin vals.push_back(mod_din); cyc.push_back(i); end
            n_checks++;
            if ({obs_ready, obs_vec()} !== {exp_ready, exp_vec()}) begin
                n_errors++;
                $display("FAIL stream_cycle %0d: got %h want %h", i, {obs_ready, obs_vec()}, {exp_ready, exp_vec()});
            end
        end
        n_checks++;
        if (vals.size() < 3 || vals[0] !== 16'd1 || vals[1] !== 16'd2 || vals[2] !== 16'd3 ||
            cyc[1] - cyc[0] != OSR || cyc[2] - cyc[1] != OSR || underrun_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL stream_order: got %0d ticks ucnt=%0d want values 1,2,3 spaced %0d ucnt=0",
                     vals.size(), underrun_cnt, OSR);
        end
    endtask

    task automatic test_underrun();
        restart();
        step(1'b1, 1'b0, 1'b1, 16'h1234);
        for (int i = 0; i < 63; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (mod_din !== 16'h1234 || underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL underrun_hold: got din=%h und=%b want 1234 0", mod_din, underrun);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        n_checks++;
        if ({mod_din, underrun, sample_tick, underrun_cnt} !== {16'h0000, 1'b1, 1'b1, 16'd1}) begin
            n_errors++;
            $display("FAIL underrun_insert: got din=%h und=%b tick=%b cnt=%0d want 0 1 1 1",
                     mod_din, underrun, sample_tick, underrun_cnt);
        end
        step(1'b1, 1'b0, 1'b1, 16'h5555);
        for (int i = 0; i < 63; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0000);
            n_checks++;
            if ({obs_ready, obs_vec()} !== {exp_ready, exp_vec()}) begin
                n_errors++;
                $display("FAIL underrun_cycle %0d: got %h want %h", i, {obs_ready, obs_vec()}, {exp_ready, exp_vec()});
            end
        end
        n_checks++;
        if ({mod_din, underrun, sample_tick, underrun_cnt} !== {16'h5555, 1'b0, 1'b1, 16'd1}) begin
            n_errors++;
            $display("FAIL underrun_resume: got din=%h und=%b tick=%b cnt=%0d want 5555 0 1 1",
                     mod_din, underrun, sample_tick, underrun_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] nv = 16'hC000;
        logic [DW-1:0] vals[$];
        int            bad = 0;
        restart();
        for (int i = 0; i < 4 * OSR + 2; i++) begin
            step(1'b1, 1'b0, 1'b1, nv);
            if (last_acc) nv = nv + 16'd1;
            if (sample_tick) vals.push_back(mod_din);
            n_checks++;
            if ({obs_ready, obs_vec()} !== {exp_ready, exp_vec()}) begin
                n_errors++;
                $display("FAIL b2b_cycle %0d: got %h want %h", i, {obs_ready, obs_vec()}, {exp_ready, exp_vec()});
            end
        end
        for (int k = 1; k < vals.size(); k++) if (vals[k] !== vals[k-1] + 16'd1) bad++;
        n_checks++;
        if (vals.size() != 5 || vals[0] !== 16'hC000 || bad != 0) begin
            n_errors++;
            $display("FAIL b2b_sequence: got %0d loads first=%h gaps=%0d want 5 loads from c000 consecutive",
                     vals.size(), (vals.size() > 0) ? vals[0] : 16'h0, bad);
        end
    endtask

    task automatic test_stop();
        logic [DW-1:0] nv = 16'h0100;
        int            cnt = 0;
        restart();
        for (int i = 0; i < 200 && !(m_state == 2 && m_pos == 10); i++) begin
            step(1'b1, 1'b0, 1'b1, nv);
            if (last_acc) nv = nv + 16'd1;
        end
        while (state !== 2'b00 && cnt < 200) begin
            step(1'b0, 1'b0, 1'b1, nv);
            cnt++;
            n_checks++;
            if ({obs_ready, obs_vec()} !== {exp_ready, exp_vec()}) begin
                n_errors++;
                $display("FAIL stop_cycle %0d: got %h want %h", cnt, {obs_ready, obs_vec()}, {exp_ready, exp_vec()});
            end
        end
        n_checks++;
        if (cnt != 54 || mod_valid_in !== 1'b0 || mod_din !== 16'h0000) begin
            n_errors++;
            $display("FAIL stop_latency: got %0d clks valid=%b din=%h want 54 0 0", cnt, mod_valid_in, mod_din);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 16'h0BAD);
        n_checks++;
        if (mod_din !== 16'h0BAD || state !== 2'b10) begin
            n_errors++;
            $display("FAIL stop_buffer_dropped: got din=%h st=%b want 0bad 10", mod_din, state);
        end
    endtask

    task automatic test_mute_reset();
        int accs = 0;
        restart();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1, 1'b1, 16'h7FFF);
            if (obs_ready) accs++;
            n_checks++;
            if ({obs_ready, obs_vec()} !== {exp_ready, exp_vec()}) begin
                n_errors++;
                $display("FAIL mute_cycle %0d: got %h want %h", i, {obs_ready, obs_vec()}, {exp_ready, exp_vec()});
            end
        end
        n_checks++;
        if (accs != 5 || mod_din !== 16'h0000 || underrun_cnt !== 16'd0 || mod_valid_in !== 1'b1) begin
            n_errors++;
            $display("FAIL mute_consume: got accepts=%0d din=%h ucnt=%0d v=%b want 5 0 0 1",
                     accs, mod_din, underrun_cnt, mod_valid_in);
        end
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b1, 16'h7FFF);
        n_checks++;
        if (obs_vec() !== 37'd0 || s_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_run: got %h ready=%b want 0 ready=0", obs_vec(), s_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic          en = 1'b1;
        logic          mu = 1'b0;
        logic          sv = 1'b0;
        logic [DW-1:0] sd = 16'h0000;
        int            dens = 90;
        restart();
        for (int i = 0; i < 6000; i++) begin
            rst_n = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) mu = ~mu;
            if ($urandom_range(0, 499) == 0) dens = $urandom_range(0, 100);
            if (!sv || last_acc) begin
                sv = ($urandom_range(0, 99) < dens);
                sd = DW'($urandom);
            end
            step(en, mu, sv, sd);
            n_checks++;
            if ({obs_ready, obs_vec()} !== {exp_ready, exp_vec()}) begin
                n_errors++;
                if (n_errors < 30)
                    $display("FAIL random_cycle %0d: got %h want %h", i, {obs_ready, obs_vec()}, {exp_ready, exp_vec()});
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mute = 1'b0; s_valid = 1'b0; s_data = '0;
        last_acc = 1'b0; exp_ready = 1'b0; obs_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_sample();
        test_stream();
        test_underrun();
        test_back_to_back();
        test_stop();
        test_mute_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
